mux_lut_cell: RTL and testbench

Parametrised, run-time-configurable K-input logic cell built as a 2^K:1 mux tree over a truth-table register. This is the successor to the fixed mux-built AND gate.
- Reset loads the AND function.
- A serial configuration port reprograms the cell to any K-input function without disturbing evaluation.
- The output is registered with a valid flag.
- Intended as the basic configurable gate in the team's mux-based logic library.

---
 rtl/mux_lut_cell_if.sv | 27 ++
 rtl/mux_lut_cell.sv | 100 ++++++++++
 tb/tb_mux_lut_cell.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mux_lut_cell_if.sv
// Evaluation and serial-configuration signals of one mux_lut_cell, grouped so
// that one handle connects a cell to its driver.
interface mux_lut_cell_if #(
  parameter int K = 2
);
  localparam int T = 1 << K;

  logic           in_valid;
  logic [K-1:0]   in_bits;
  logic           y;
  logic           y_valid;
  logic           cfg_en;
  logic           cfg_bit;
  logic           cfg_busy;
  logic           cfg_done;
  logic [T-1:0]   table_o;

  modport master (
    output in_valid, in_bits, cfg_en, cfg_bit,
    input  y, y_valid, cfg_busy, cfg_done, table_o
  );

  modport slave (
    input  in_valid, in_bits, cfg_en, cfg_bit,
    output y, y_valid, cfg_busy, cfg_done, table_o
  );
endinterface

// File: rtl/mux_lut_cell.sv
// Run-time configurable K-input logic cell: a 2^K:1 mux tree over a truth-table
// register that is reloaded serially, LSB first, without stalling evaluation.
module mux_lut_cell #(
  parameter int K       = 2,
  parameter bit REG_OUT = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  mux_lut_cell_if.slave   bus
);
  localparam int T = 1 << K;
  localparam logic [T-1:0] AND_TABLE = {1'b1, {(T-1){1'b0}}};
  localparam logic [K:0]   T_CNT     = (K+1)'(T);
  localparam logic [K:0]   CNT_ONE   = {{K{1'b0}}, 1'b1};

  typedef enum logic {RUN, LOAD} state_t;

  state_t         state;
  logic [T-1:0]   active;
  logic [T-1:0]   shadow;
  logic [T-1:0]   shifted;
  logic [K:0]     cnt;
  logic [K:0]     cnt_inc;
  logic           commit;
  logic           cfg_busy_r;
  logic           cfg_done_r;
  logic [K:0][T-1:0] lvl;
  logic           mux_out;

  // Level l of the tree is selected by in_bits[l]; in_bits[K-1] drives the root.
  always_comb begin
    lvl    = '0;
    lvl[0] = active;
    for (int unsigned l = 0; l < K; l++) begin
      for (int unsigned i = 0; i < T/2; i++) begin
        if (i < (T >> (l+1)))
          lvl[l+1][i] = bus.in_bits[l] ? lvl[l][2*i+1] : lvl[l][2*i];
      end
    end
    mux_out = lvl[K][0];
  end

  always_comb begin
    shifted = {bus.cfg_bit, shadow[T-1:1]};
    cnt_inc = ((state == RUN) ? '0 : cnt) + CNT_ONE;
    commit  = bus.cfg_en && (cnt_inc == T_CNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active     <= AND_TABLE;
      shadow     <= '0;
      cnt        <= '0;
      state      <= RUN;
      cfg_busy_r <= 1'b0;
      cfg_done_r <= 1'b0;
    end else begin
      cfg_done_r <= 1'b0;
      if (bus.cfg_en) begin
        shadow <= shifted;
        if (commit) begin
          active     <= shifted;
          cnt        <= '0;
          state      <= RUN;
          cfg_busy_r <= 1'b0;
          cfg_done_r <= 1'b1;
        end else begin
          cnt        <= cnt_inc;
          state      <= LOAD;
          cfg_busy_r <= 1'b1;
        end
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg
      logic y_r;
      logic y_valid_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          y_r       <= 1'b0;
          y_valid_r <= 1'b0;
        end else begin
          y_valid_r <= bus.in_valid;
          if (bus.in_valid) y_r <= mux_out;
        end
      end
      assign bus.y       = y_r;
      assign bus.y_valid = y_valid_r;
    end else begin : g_comb
      assign bus.y       = mux_out;
      assign bus.y_valid = bus.in_valid;
    end
  endgenerate

  assign bus.cfg_busy = cfg_busy_r;
  assign bus.cfg_done = cfg_done_r;
  assign bus.table_o  = active;
endmodule

// File: tb/tb_mux_lut_cell.sv
// Bench for mux_lut_cell: a registered K=2 cell and a combinational K=3 cell,
// each with a scoreboard queue drained by its own output monitor.
module tb_mux_lut_cell;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mux_lut_cell_if #(.K(2)) r ();
  mux_lut_cell_if #(.K(3)) c ();

  mux_lut_cell #(.K(2), .REG_OUT(1'b1)) dut_r (.clk(clk), .rst(rst), .bus(r));
  mux_lut_cell #(.K(3), .REG_OUT(1'b0)) dut_c (.clk(clk), .rst(rst), .bus(c));

  bit q_r[$];
  bit q_c[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors sample on the falling edge, away from where inputs change.
  initial begin
    forever begin
      @(negedge clk);
      if (r.y_valid === 1'b1) begin
        if (q_r.size() == 0) check("r_unexpected_valid", 32'd1, 32'd0);
        else check("r_y", {31'd0, r.y}, {31'd0, q_r.pop_front()});
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (c.y_valid === 1'b1) begin
        if (q_c.size() == 0) check("c_unexpected_valid", 32'd1, 32'd0);
        else check("c_y", {31'd0, c.y}, {31'd0, q_c.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic eval_r(input logic [1:0] bits, input bit exp);
    r.in_valid = 1'b1;
    r.in_bits  = bits;
    q_r.push_back(exp);
    tick();
    r.in_valid = 1'b0;
  endtask

  task automatic send_r(input bit b);
    r.cfg_en  = 1'b1;
    r.cfg_bit = b;
    tick();
    r.cfg_en  = 1'b0;
  endtask

  task automatic send_c(input bit b);
    c.cfg_en  = 1'b1;
    c.cfg_bit = b;
    tick();
    c.cfg_en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] or_tab;
    logic [3:0] xor_tab;
    logic [7:0] maj;
    or_tab  = 4'b1110;
    xor_tab = 4'b0110;
    maj     = 8'hE8;

    r.in_valid = 0; r.in_bits = '0; r.cfg_en = 0; r.cfg_bit = 0;
    c.in_valid = 0; c.in_bits = '0; c.cfg_en = 0; c.cfg_bit = 0;
    rst = 1'b1;
    tick();
    tick();
    check("rst_y",        {31'd0, r.y},        32'd0);
    check("rst_y_valid",  {31'd0, r.y_valid},  32'd0);
    check("rst_busy",     {31'd0, r.cfg_busy}, 32'd0);
    check("rst_done",     {31'd0, r.cfg_done}, 32'd0);
    check("rst_table",    {28'd0, r.table_o},  32'h8);
    check("rst_table_c",  {24'd0, c.table_o},  32'h80);
    rst = 1'b0;

    // 1: AND
    eval_r(2'd0, 1'b0);
    eval_r(2'd1, 1'b0);
    eval_r(2'd2, 1'b0);
    eval_r(2'd3, 1'b1);
    tick();
    check("idle_y_valid", {31'd0, r.y_valid}, 32'd0);

    // 2: load OR, bits LSB first
    for (int i = 0; i < 4; i++) begin
      send_r(or_tab[i]);
      if (i < 3) check("load_busy", {31'd0, r.cfg_busy}, 32'd1);
    end
    check("or_busy_end", {31'd0, r.cfg_busy}, 32'd0);
    check("or_done",     {31'd0, r.cfg_done}, 32'd1);
    check("or_table",    {28'd0, r.table_o},  32'hE);
    tick();
    check("done_pulse",  {31'd0, r.cfg_done}, 32'd0);
    for (int i = 0; i < 4; i++) eval_r(2'(i), or_tab[i]);
    tick();

    // 3: XOR with a pause mid-load
    send_r(xor_tab[0]);
    send_r(xor_tab[1]);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_busy", {31'd0, r.cfg_busy}, 32'd1);
    end
    check("pause_table", {28'd0, r.table_o}, 32'hE);
    send_r(xor_tab[2]);
    check("pause_busy3", {31'd0, r.cfg_busy}, 32'd1);
    send_r(xor_tab[3]);
    check("xor_done",  {31'd0, r.cfg_done}, 32'd1);
    check("xor_table", {28'd0, r.table_o},  32'h6);
    for (int i = 0; i < 4; i++) eval_r(2'(i), xor_tab[i]);
    tick();

    // 4: evaluation on the commit cycle sees the old table
    do_reset();
    for (int i = 0; i < 3; i++) send_r(or_tab[i]);
    r.cfg_en = 1'b1; r.cfg_bit = or_tab[3];
    r.in_valid = 1'b1; r.in_bits = 2'b01;
    q_r.push_back(1'b0);
    tick();
    r.cfg_en = 1'b0;
    r.in_valid = 1'b1; r.in_bits = 2'b01;
    q_r.push_back(1'b1);
    tick();
    r.in_valid = 1'b0;
    check("commit_table", {28'd0, r.table_o}, 32'hE);

    // fresh load straight after a commit: all four bits are needed again
    send_r(1'b1);
    check("fresh_busy",  {31'd0, r.cfg_busy}, 32'd1);
    send_r(1'b1);
    send_r(1'b1);
    check("fresh_busy3", {31'd0, r.cfg_busy}, 32'd1);
    check("fresh_hold",  {28'd0, r.table_o},  32'hE);
    send_r(1'b1);
    check("fresh_table", {28'd0, r.table_o},  32'hF);
    tick();

    // 5: reset mid-load, with in_valid on the reset cycle
    do_reset();
    send_r(1'b0);
    send_r(1'b1);
    check("mid_busy", {31'd0, r.cfg_busy}, 32'd1);
    rst = 1'b1;
    r.in_valid = 1'b1; r.in_bits = 2'b11;
    tick();
    r.in_valid = 1'b0;
    check("rst_mid_busy",   {31'd0, r.cfg_busy}, 32'd0);
    check("rst_mid_done",   {31'd0, r.cfg_done}, 32'd0);
    check("rst_mid_table",  {28'd0, r.table_o},  32'h8);
    check("rst_mid_y",      {31'd0, r.y},        32'd0);
    check("rst_mid_yvalid", {31'd0, r.y_valid},  32'd0);
    rst = 1'b0;
    tick();
    check("post_rst_done",  {31'd0, r.cfg_done}, 32'd0);

    // 6: K=3 combinational majority
    for (int i = 0; i < 8; i++) send_c(maj[i]);
    check("maj_done",  {31'd0, c.cfg_done}, 32'd1);
    check("maj_table", {24'd0, c.table_o},  32'hE8);
    c.in_valid = 1'b1; c.in_bits = 3'b011; q_c.push_back(1'b1);
    tick();
    c.in_bits = 3'b100; q_c.push_back(1'b0);
    tick();
    c.in_bits = 3'b111; q_c.push_back(1'b1);
    tick();
    c.in_valid = 1'b0;
    #1;
    check("c_y_valid_low", {31'd0, c.y_valid}, 32'd0);
    tick();
    tick();

    check("r_queue_empty", q_r.size(), 32'd0);
    check("c_queue_empty", q_c.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
